ahbl_mmio_decoder: RTL and testbench
====================================

AHBL_MMIO_DECODER -- requirements
Module: ahbl_mmio_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of MMIO slave slots (1..8).
REQ-002 SHALL have parameter SLOT_LSB, default 16, log2 of slot size in bytes.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h7000_0000, address of slot 0, aligned to 2^SLOT_LSB.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, wait-state limit (used only when AHBL_DEC_TIMEOUT_EN is defined).
REQ-005 SHALL have ports HCLK in 1 (clock) and HRESETN in 1 (reset; asynchronous, active-low).
REQ-006 SHALL have master-side inputs HSEL 1, HADDR 32, HTRANS 2, and outputs HREADY 1, HRESP 1, HRDATA 32.
REQ-007 SHALL have slave-side outputs HSEL_S NUM_SLAVES and HREADY_S 1 (the master HREADY, broadcast to all slaves).
REQ-008 SHALL have slave-side inputs HREADYOUT_S NUM_SLAVES, HRESP_S NUM_SLAVES, and HRDATA_S 32*NUM_SLAVES (slot i occupies bits [32i+31:32i]).
REQ-009 SHALL have output TIMEOUT_IRQ 1: a one-cycle pulse when a transfer is timed out.
REQ-010 SHALL NOT route HADDR, HWDATA, HWRITE, HSIZE or HPROT to the slaves; the enclosing top level broadcasts these.

Function
REQ-011 SHALL select slot i when HSEL=1 and HADDR[31:SLOT_LSB] == BASE_ADDR[31:SLOT_LSB]+i, for i < NUM_SLAVES.
REQ-012 SHALL drive HSEL_S combinationally in the address phase; at most one bit SHALL be set.
REQ-013 SHALL accept an address phase when HSEL & HREADY & HTRANS[1].
REQ-014 SHALL register the data-phase target (slot index, default-slave flag, active flag) only on cycles where HREADY=1.
REQ-015 SHALL treat an accepted transfer that hits no slot as default-slave: HREADY=0/HRESP=1 in cycle 1, then HREADY=1/HRESP=1 in cycle 2.
REQ-016 SHALL, in a slot data phase, pass that slot's HREADYOUT_S, HRESP_S and HRDATA_S to the master unregistered (zero added latency).
REQ-017 SHALL, with no active data phase (IDLE/BUSY, or HSEL=0), drive HREADY=1, HRESP=0, HRDATA=0.
REQ-018 SHALL support back-to-back transfers to different slots with no idle cycle.
REQ-019 SHALL allow a new address phase to be decoded while a data phase is stalled, but SHALL NOT update the data-phase register until HREADY=1.
REQ-020 SHALL hold TIMEOUT_IRQ at 0 when the timeout feature is compiled out.

Reset
REQ-021 SHALL, while HRESETN=0, clear the data-phase register, the timeout counter and the timeout FSM, and drive HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_IRQ=0.
REQ-022 SHALL abandon any in-flight transfer on reset assertion mid-operation; there SHALL be no residual response after release.

Configuration
REQ-023 SHALL compile in the wait-state watchdog when macro AHBL_DEC_TIMEOUT_EN is defined.
REQ-024 SHALL, with AHBL_DEC_TIMEOUT_EN defined, count cycles while a slot data phase has HREADYOUT_S=0, and clear the count when HREADYOUT_S=1 or a new phase starts.
REQ-025 SHALL, on reaching TIMEOUT_CYCLES, pulse TIMEOUT_IRQ once and issue the two-cycle ERROR response of REQ-015, ignoring that slot's outputs.
REQ-026 SHALL have a timeout FSM with states IDLE -> WAIT -> ERR1 -> ERR2 -> IDLE.
REQ-027 SHALL, without the macro, contain no counter or timeout FSM; a stalled slave stalls the master indefinitely.

Structure
REQ-028 SHALL place the default-slave/timeout state enum, the AHB HTRANS encodings and the ERROR/OKAY constants in shared package ahbl_pkg.
REQ-029 SHALL implement the default slave plus watchdog as sub-module ahbl_default_slave (states IDLE, WAIT, ERR1, ERR2), instantiated once.
REQ-030 SHALL keep the decoder and response mux in the parent module.

Verification
REQ-031 SHALL verify: NONSEQ read to 0x7001_0004 with slot 1 giving HRDATA 0xDEADBEEF after 2 wait states -> HSEL_S=0010, HREADY low for 2 cycles, HRDATA=0xDEADBEEF, HRESP=0.
REQ-032 SHALL verify: NONSEQ to 0x7004_0000 (NUM_SLAVES=4) -> HSEL_S=0000, cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1.
REQ-033 SHALL verify: back-to-back writes to slots 0, 3, 0 -> HSEL_S sequence 0001, 1000, 0001, with each response taken from the matching slot.
REQ-034 SHALL verify: with AHBL_DEC_TIMEOUT_EN, TIMEOUT_CYCLES=16, slot 2 holding HREADYOUT low -> TIMEOUT_IRQ pulses at stall cycle 16, then two-cycle ERROR; without the macro, HREADY stays low.
REQ-035 SHALL verify: HRESETN asserted during a slot-1 wait state -> HREADY=1, HRESP=0 immediately; first transfer after release decodes normally.
REQ-036 SHALL verify: HTRANS=IDLE with HSEL=1 -> HSEL_S asserted, no data phase, HREADY=1 and HRESP=0 the next cycle.

Source files
------------

// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite transfer/response encodings and default-slave state type
package ahbl_pkg;
    typedef enum logic [1:0] {DS_IDLE, DS_WAIT, DS_ERR1, DS_ERR2} ds_state_t;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;
endpackage

// File: rtl/ahbl_default_slave.sv
// ahbl_default_slave: two-cycle ERROR responder plus optional wait-state watchdog (AHBL_DEC_TIMEOUT_EN)
module ahbl_default_slave
    import ahbl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ready,
    input  logic nxt_def,
`ifdef AHBL_DEC_TIMEOUT_EN
    input  logic nxt_slot,
    input  logic slot_ready,
`endif
    output logic err_phase,
    output logic err_ready,
    output logic timeout_irq
);
    ds_state_t state, state_nxt;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AHBL_DEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic expire;
    assign expire = state == DS_WAIT && !slot_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign timeout_irq = expire;
    // count consecutive stalled cycles of the watched slot; any progress or timeout restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (state == DS_WAIT && !slot_ready && !expire) ? cnt + 1'b1 : '0;
    end
`else
    assign timeout_irq = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DS_IDLE;
        else state <= state_nxt;
    end

    // next state: a new data phase is only taken when the bus is ready
    always_comb begin
        state_nxt = state;
        if (state == DS_ERR1) state_nxt = DS_ERR2;
`ifdef AHBL_DEC_TIMEOUT_EN
        else if (expire) state_nxt = DS_ERR1;
        else if (ready) state_nxt = nxt_def ? DS_ERR1 : nxt_slot ? DS_WAIT : DS_IDLE;
`else
        else if (ready) state_nxt = nxt_def ? DS_ERR1 : DS_IDLE;
`endif
    end

    // outputs: own the response during both ERROR cycles, ready only in the second
    always_comb begin
        err_phase = state == DS_ERR1 || state == DS_ERR2;
        err_ready = state == DS_ERR2;
    end
endmodule

// File: rtl/ahbl_mmio_decoder.sv
// ahbl_mmio_decoder: AHB-Lite MMIO slot decoder and response mux; watchdog via AHBL_DEC_TIMEOUT_EN
module ahbl_mmio_decoder
    import ahbl_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          SLOT_LSB       = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h7000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                    HCLK,
    input  logic                    HRESETN,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    output logic                    HREADY,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [NUM_SLAVES-1:0]   HSEL_S,
    output logic                    HREADY_S,
    input  logic [NUM_SLAVES-1:0]   HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]   HRESP_S,
    input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
    output logic                    TIMEOUT_IRQ
);
    localparam int AW = 32 - SLOT_LSB;
    localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_slaves
        $error("NUM_SLAVES must be 1..8");
    end

    logic [AW-1:0] offset;
    logic          hit, accept, err_phase, err_ready, dp_active, unused_bits;
    logic [SW-1:0] dp_slot;

    assign offset      = HADDR[31:SLOT_LSB] - BASE_ADDR[31:SLOT_LSB];
    assign hit         = HSEL && offset < AW'(NUM_SLAVES);
    assign accept      = HSEL && HREADY && HTRANS[1];
    assign HREADY_S    = HREADY;
    assign unused_bits = ^{HADDR[SLOT_LSB-1:0], HTRANS[0]};

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
        assign HSEL_S[i] = hit && offset == AW'(i);
    end

    // data-phase target, advanced only when the current data phase completes
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_active <= 1'b0;
            dp_slot   <= '0;
        end else if (HREADY) begin
            dp_active <= accept && hit;
            dp_slot   <= offset[SW-1:0];
        end
    end

    ahbl_default_slave #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_default_slave (
        .clk        (HCLK),
        .rst_n      (HRESETN),
        .ready      (HREADY),
        .nxt_def    (accept && !hit),
`ifdef AHBL_DEC_TIMEOUT_EN
        .nxt_slot   (accept && hit),
        .slot_ready (HREADYOUT_S[dp_slot]),
`endif
        .err_phase  (err_phase),
        .err_ready  (err_ready),
        .timeout_irq(TIMEOUT_IRQ)
    );

    // response mux: ERROR sequence overrides the slot, otherwise pass the slot through unregistered
    always_comb begin
        HREADY = err_phase ? err_ready : dp_active ? HREADYOUT_S[dp_slot] : 1'b1;
        HRESP  = err_phase ? RESP_ERROR : dp_active ? HRESP_S[dp_slot] : RESP_OKAY;
        HRDATA = (!err_phase && dp_active) ? HRDATA_S[32*dp_slot +: 32] : 32'h0;
    end
endmodule

// File: tb/tb_ahbl_mmio_decoder.sv
// tb_ahbl_mmio_decoder: directed self-checking bench for ahbl_mmio_decoder (honours AHBL_DEC_TIMEOUT_EN)
module tb_ahbl_mmio_decoder;
    logic         HCLK, HRESETN, HSEL, HREADY, HRESP, HREADY_S, TIMEOUT_IRQ;
    logic [31:0]  HADDR, HRDATA;
    logic [1:0]   HTRANS;
    logic [3:0]   HSEL_S, HREADYOUT_S, HRESP_S;
    logic [127:0] HRDATA_S;
    int passed = 0;
    int total  = 0;

    ahbl_mmio_decoder #(.NUM_SLAVES(4), .SLOT_LSB(16), .BASE_ADDR(32'h7000_0000), .TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HSEL_S(HSEL_S), .HREADY_S(HREADY_S),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S), .TIMEOUT_IRQ(TIMEOUT_IRQ)
    );

    initial begin
        HCLK = 0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans);
        HSEL = sel;
        HADDR = addr;
        HTRANS = trans;
    endtask

    task automatic set_slave(input int i, input logic rdy, input logic resp, input logic [31:0] data);
        HREADYOUT_S[i] = rdy;
        HRESP_S[i] = resp;
        HRDATA_S[i*32 +: 32] = data;
    endtask

    task automatic test_reset;
        HRESETN = 0;
        drive(0, 32'h0, 2'b00);
        HREADYOUT_S = 4'hF;
        HRESP_S = 4'h0;
        HRDATA_S = '0;
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL reset_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRESP !== 1'b0) $display("FAIL reset_hresp got=%b exp=0", HRESP); else passed++;
        total++; if (HRDATA !== 32'h0) $display("FAIL reset_hrdata got=%h exp=0", HRDATA); else passed++;
        total++; if (TIMEOUT_IRQ !== 1'b0) $display("FAIL reset_irq got=%b exp=0", TIMEOUT_IRQ); else passed++;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETN = 1;
        @(negedge HCLK);
    endtask

    task automatic test_read_wait;
        set_slave(1, 0, 0, 32'h0);
        drive(1, 32'h7001_0004, 2'b10);
        #1;
        total++; if (HSEL_S !== 4'b0010) $display("FAIL rd_hsel_s got=%b exp=0010", HSEL_S); else passed++;
        total++; if (HREADY !== 1'b1) $display("FAIL rd_addr_hready got=%b exp=1", HREADY); else passed++;
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        #1;
        total++; if (HREADY !== 1'b0) $display("FAIL rd_wait1 got=%b exp=0", HREADY); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HREADY !== 1'b0) $display("FAIL rd_wait2 got=%b exp=0", HREADY); else passed++;
        @(negedge HCLK);
        set_slave(1, 1, 0, 32'hDEAD_BEEF);
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL rd_done_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRDATA !== 32'hDEAD_BEEF) $display("FAIL rd_hrdata got=%h exp=deadbeef", HRDATA); else passed++;
        total++; if (HRESP !== 1'b0) $display("FAIL rd_hresp got=%b exp=0", HRESP); else passed++;
        total++; if (HREADY_S !== 1'b1) $display("FAIL rd_hready_s got=%b exp=1", HREADY_S); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HRDATA !== 32'h0) $display("FAIL rd_idle_hrdata got=%h exp=0", HRDATA); else passed++;
    endtask

    task automatic test_default_slave;
        drive(1, 32'h7004_0000, 2'b10);
        #1;
        total++; if (HSEL_S !== 4'b0000) $display("FAIL miss_hsel_s got=%b exp=0000", HSEL_S); else passed++;
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        #1;
        total++; if (HREADY !== 1'b0) $display("FAIL miss_c1_hready got=%b exp=0", HREADY); else passed++;
        total++; if (HRESP !== 1'b1) $display("FAIL miss_c1_hresp got=%b exp=1", HRESP); else passed++;
        total++; if (HREADY_S !== 1'b0) $display("FAIL miss_c1_hready_s got=%b exp=0", HREADY_S); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL miss_c2_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRESP !== 1'b1) $display("FAIL miss_c2_hresp got=%b exp=1", HRESP); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HRESP !== 1'b0) $display("FAIL miss_after_hresp got=%b exp=0", HRESP); else passed++;
        drive(1, 32'h6FFF_0000, 2'b00);
        #1;
        total++; if (HSEL_S !== 4'b0000) $display("FAIL below_base_hsel_s got=%b exp=0000", HSEL_S); else passed++;
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
    endtask

    task automatic test_back_to_back;
        set_slave(0, 1, 0, 32'hA0A0_0000);
        set_slave(3, 1, 0, 32'hA3A3_0003);
        drive(1, 32'h7000_0000, 2'b10);
        #1;
        total++; if (HSEL_S !== 4'b0001) $display("FAIL b2b_sel0 got=%b exp=0001", HSEL_S); else passed++;
        @(negedge HCLK);
        drive(1, 32'h7003_0010, 2'b10);
        #1;
        total++; if (HSEL_S !== 4'b1000) $display("FAIL b2b_sel3 got=%b exp=1000", HSEL_S); else passed++;
        total++; if (HRDATA !== 32'hA0A0_0000) $display("FAIL b2b_data0 got=%h exp=a0a00000", HRDATA); else passed++;
        @(negedge HCLK);
        drive(1, 32'h7000_0020, 2'b10);
        #1;
        total++; if (HSEL_S !== 4'b0001) $display("FAIL b2b_sel0b got=%b exp=0001", HSEL_S); else passed++;
        total++; if (HRDATA !== 32'hA3A3_0003) $display("FAIL b2b_data3 got=%h exp=a3a30003", HRDATA); else passed++;
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        #1;
        total++; if (HRDATA !== 32'hA0A0_0000) $display("FAIL b2b_data0b got=%h exp=a0a00000", HRDATA); else passed++;
        total++; if (HREADY !== 1'b1) $display("FAIL b2b_hready got=%b exp=1", HREADY); else passed++;
        @(negedge HCLK);
    endtask

    task automatic test_stall_decode;
        set_slave(1, 0, 0, 32'h0);
        set_slave(2, 1, 0, 32'h0);
        drive(1, 32'h7001_0000, 2'b10);
        @(negedge HCLK);
        drive(1, 32'h7002_0000, 2'b10);
        #1;
        total++; if (HSEL_S !== 4'b0100) $display("FAIL stall_hsel_s got=%b exp=0100", HSEL_S); else passed++;
        total++; if (HREADY !== 1'b0) $display("FAIL stall_hready got=%b exp=0", HREADY); else passed++;
        @(negedge HCLK);
        set_slave(2, 0, 1, 32'h2222_2222);
        set_slave(1, 0, 0, 32'h1111_1111);
        #1;
        total++; if (HREADY !== 1'b0) $display("FAIL stall_hold got=%b exp=0", HREADY); else passed++;
        set_slave(1, 1, 0, 32'h1111_1111);
        #1;
        total++; if (HRDATA !== 32'h1111_1111) $display("FAIL stall_data1 got=%h exp=11111111", HRDATA); else passed++;
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        set_slave(2, 1, 0, 32'h2222_2222);
        #1;
        total++; if (HRDATA !== 32'h2222_2222) $display("FAIL stall_data2 got=%h exp=22222222", HRDATA); else passed++;
        @(negedge HCLK);
    endtask

    task automatic test_timeout;
        set_slave(2, 0, 0, 32'h5555_5555);
        drive(1, 32'h7002_0000, 2'b10);
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        for (int k = 1; k <= 16; k++) begin
            #1;
            total++; if (HREADY !== 1'b0) $display("FAIL to_stall%0d_hready got=%b exp=0", k, HREADY); else passed++;
`ifdef AHBL_DEC_TIMEOUT_EN
            total++; if (TIMEOUT_IRQ !== (k == 16)) $display("FAIL to_stall%0d_irq got=%b exp=%b", k, TIMEOUT_IRQ, k == 16); else passed++;
`else
            total++; if (TIMEOUT_IRQ !== 1'b0) $display("FAIL to_stall%0d_irq got=%b exp=0", k, TIMEOUT_IRQ); else passed++;
`endif
            @(negedge HCLK);
        end
        #1;
`ifdef AHBL_DEC_TIMEOUT_EN
        total++; if (HREADY !== 1'b0) $display("FAIL to_err1_hready got=%b exp=0", HREADY); else passed++;
        total++; if (HRESP !== 1'b1) $display("FAIL to_err1_hresp got=%b exp=1", HRESP); else passed++;
        total++; if (HRDATA !== 32'h0) $display("FAIL to_err1_hrdata got=%h exp=0", HRDATA); else passed++;
        total++; if (TIMEOUT_IRQ !== 1'b0) $display("FAIL to_err1_irq got=%b exp=0", TIMEOUT_IRQ); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL to_err2_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRESP !== 1'b1) $display("FAIL to_err2_hresp got=%b exp=1", HRESP); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HRESP !== 1'b0) $display("FAIL to_after_hresp got=%b exp=0", HRESP); else passed++;
`else
        for (int k = 0; k < 4; k++) @(negedge HCLK);
        #1;
        total++; if (HREADY !== 1'b0) $display("FAIL to_hang_hready got=%b exp=0", HREADY); else passed++;
        set_slave(2, 1, 0, 32'h5555_5555);
        #1;
        total++; if (HRDATA !== 32'h5555_5555) $display("FAIL to_release_hrdata got=%h exp=55555555", HRDATA); else passed++;
        @(negedge HCLK);
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL to_after_hready got=%b exp=1", HREADY); else passed++;
`endif
        set_slave(2, 1, 0, 32'h0);
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid;
        set_slave(1, 0, 0, 32'h0);
        set_slave(0, 1, 0, 32'hC0C0_C0C0);
        drive(1, 32'h7001_0000, 2'b10);
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        #1;
        total++; if (HREADY !== 1'b0) $display("FAIL rstmid_wait got=%b exp=0", HREADY); else passed++;
        #1 HRESETN = 0;
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL rstmid_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRESP !== 1'b0) $display("FAIL rstmid_hresp got=%b exp=0", HRESP); else passed++;
        @(negedge HCLK);
        HRESETN = 1;
        drive(1, 32'h7000_0000, 2'b10);
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL rstmid_next_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRDATA !== 32'hC0C0_C0C0) $display("FAIL rstmid_next_data got=%h exp=c0c0c0c0", HRDATA); else passed++;
        set_slave(1, 1, 0, 32'h0);
        @(negedge HCLK);
    endtask

    task automatic test_idle;
        set_slave(2, 0, 1, 32'h7777_7777);
        drive(1, 32'h7002_0000, 2'b00);
        #1;
        total++; if (HSEL_S !== 4'b0100) $display("FAIL idle_hsel_s got=%b exp=0100", HSEL_S); else passed++;
        @(negedge HCLK);
        drive(0, 32'h0, 2'b00);
        #1;
        total++; if (HREADY !== 1'b1) $display("FAIL idle_hready got=%b exp=1", HREADY); else passed++;
        total++; if (HRESP !== 1'b0) $display("FAIL idle_hresp got=%b exp=0", HRESP); else passed++;
        total++; if (HRDATA !== 32'h0) $display("FAIL idle_hrdata got=%h exp=0", HRDATA); else passed++;
        set_slave(2, 1, 0, 32'h0);
        @(negedge HCLK);
    endtask

    initial begin
        test_reset;
        test_read_wait;
        test_default_slave;
        test_back_to_back;
        test_stall_decode;
        test_timeout;
        test_reset_mid;
        test_idle;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
